// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer.
//   - slice OPMODE encodings used by the sequencer
//   - per-slot tag carried alongside each operand pair
//   - sequencer FSM states
//   - operand / product widths
// Optional feature macro: DSP48A1_MAC_BIAS_EN (first term adds the C port).
package dsp48a1_pkg;

  localparam int A_W = 18;
  localparam int P_W = 48;

  // OPMODE = {pre/post-add ctl, carryin, Z[1:0], X[1:0]} subset used here.
  localparam logic [7:0] OPM_CLR   = 8'h00;  // X=0, Z=0
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_BIAS  = 8'h0D;  // X=M, Z=C

`ifdef DSP48A1_MAC_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  typedef enum logic [1:0] {
    ACC,
    FLUSH,
    HOLD
  } state_t;

  function automatic logic [7:0] tag_opmode(input tag_t t);
    if (!t.valid) return OPM_HOLD;
    if (t.first)  return BIAS_EN ? OPM_BIAS : OPM_FIRST;
    return OPM_ACC;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_seq_tag_pipe.sv
// Tag shift register that travels alongside the slice pipeline.
// Stage 0 is loaded on the same edge that loads dsp_a/dsp_b, so stage k
// describes the slot presented to the slice k cycles earlier.
// Ports:
//   clk, rst_n  clock, asynchronous active-low clear
//   abort       synchronous clear of every stage
//   tag_in      tag for the slot being issued this cycle (bubble = '0)
//   tag_opm     tag whose opmode must be registered now so that it sits on
//               dsp_opmode OPM_DLY cycles after the slot's operands
//   cap_last    the last term of a frame is at stage DSP_LAT (P is final)
module dsp48a1_tag_pipe
  import dsp48a1_pkg::*;
#(
  parameter int unsigned DSP_LAT = 3,
  parameter int unsigned OPM_DLY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  input  tag_t tag_in,
  output tag_t tag_opm,
  output logic cap_last
);

  tag_t stage [DSP_LAT+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= DSP_LAT; i++) stage[i] <= '0;
    end else if (abort) begin
      for (int unsigned i = 0; i <= DSP_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i <= DSP_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // dsp_opmode is itself a register, so read one stage early.
  assign tag_opm  = stage[OPM_DLY-1];
  assign cap_last = stage[DSP_LAT].valid && stage[DSP_LAT].last;

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// Upstream sequencer for an external DSP48A1 slice computing a LEN-term
// dot product P = sum(A*B), one operand pair per cycle.
// Optional feature macro: DSP48A1_MAC_BIAS_EN -- adds port 'bias', sampled
// on the first-term handshake and driven on dsp_c; first opmode becomes 0D.
// Ports:
//   clk, rst_n, abort           clock, async active-low reset, sync abort
//   in_valid/in_ready/in_a/in_b signed 18-bit operand stream
//   res_valid/res_ready/res_p   signed 48-bit result register
//   dsp_a/b/d/c/opmode/ce       slice inputs (D unused, C = bias or 0)
//   dsp_p                       slice P output
module dsp48a1_mac_seq
  import dsp48a1_pkg::*;
#(
  parameter int unsigned LEN     = 4,
  parameter int unsigned DSP_LAT = 3,
  parameter int unsigned OPM_DLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [A_W-1:0] in_a,
  input  logic signed [A_W-1:0] in_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [P_W-1:0] res_p,
  output logic signed [A_W-1:0] dsp_a,
  output logic signed [A_W-1:0] dsp_b,
  output logic signed [A_W-1:0] dsp_d,
  output logic signed [P_W-1:0] dsp_c,
  output logic [7:0]            dsp_opmode,
  output logic                  dsp_ce,
  input  logic signed [P_W-1:0] dsp_p
`ifdef DSP48A1_MAC_BIAS_EN
  ,
  input  logic signed [P_W-1:0] bias
`endif
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             cnt_first;
  logic             cnt_last;
  tag_t             push_tag;
  tag_t             tag_opm;
  logic             cap_last;

  assign hs        = in_valid && in_ready;
  assign cnt_first = (cnt == '0);
  assign cnt_last  = (cnt == CNT_W'(LEN - 1));

  always_comb begin
    push_tag = '0;
    if (hs) begin
      push_tag.valid = 1'b1;
      push_tag.first = cnt_first;
      push_tag.last  = cnt_last;
    end
  end

  dsp48a1_tag_pipe #(
    .DSP_LAT (DSP_LAT),
    .OPM_DLY (OPM_DLY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (abort),
    .tag_in   (push_tag),
    .tag_opm  (tag_opm),
    .cap_last (cap_last)
  );

  assign dsp_d = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      cnt        <= '0;
      in_ready   <= 1'b0;
      res_valid  <= 1'b0;
      res_p      <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_opmode <= OPM_CLR;
      dsp_ce     <= 1'b0;
    end else begin
      dsp_ce <= 1'b1;
      if (abort) begin
        // One cycle of OPM_CLR zeroes P so a partial sum never leaks.
        state      <= ACC;
        cnt        <= '0;
        in_ready   <= 1'b1;
        res_valid  <= 1'b0;
        dsp_opmode <= OPM_CLR;
      end else begin
        dsp_opmode <= tag_opmode(tag_opm);
        if (hs) begin
          dsp_a <= in_a;
          dsp_b <= in_b;
        end
        case (state)
          ACC: begin
            in_ready <= !(hs && cnt_last);
            if (hs) begin
              if (cnt_last) begin
                cnt   <= '0;
                state <= FLUSH;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          FLUSH: begin
            if (cap_last) begin
              res_p     <= dsp_p;
              res_valid <= 1'b1;
              state     <= HOLD;
            end
          end
          HOLD: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ACC;
            end
          end
          default: state <= ACC;
        endcase
      end
    end
  end

`ifdef DSP48A1_MAC_BIAS_EN
  logic signed [P_W-1:0] c_q;

  // Held until the next frame's first term; CREG in the slice aligns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
    end else if (!abort && hs && cnt_first) begin
      c_q <= bias;
    end
  end

  assign dsp_c = c_q;
`else
  assign dsp_c = '0;
`endif

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
`timescale 1ns/1ps
module tb_dsp48a1_mac_seq;

  localparam int unsigned DSP_LAT = 3;
`ifdef DSP48A1_MAC_BIAS_EN
  localparam logic [7:0] EXP_FIRST = 8'h0D;
`else
  localparam logic [7:0] EXP_FIRST = 8'h01;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic abort = 1'b0;

  // lane 0: LEN=4, lane 1: LEN=1
  logic [1:0]        in_valid, in_ready, res_valid, res_ready, dsp_ce;
  logic [1:0][17:0]  in_a, in_b, dsp_a, dsp_b, dsp_d;
  logic [1:0][47:0]  res_p, dsp_c, bias;
  logic [1:0][7:0]   dsp_opmode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];
  logic signed [17:0] va[8];
  logic signed [17:0] vb[8];

  bit rec = 1'b0;
  logic [7:0] opm_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gl
    // Behavioural DSP48A1: AREG/BREG=1, MREG=1, PREG=1, OPMODEREG=1, CREG=1.
    logic signed [17:0] a_r = '0;
    logic signed [17:0] b_r = '0;
    logic signed [35:0] m_r = '0;
    logic [7:0]         opm_r = '0;
    logic [47:0]        c_r = '0;
    logic [47:0]        p_r = '0;
    logic [47:0]        x_v, z_v;

    always_comb begin
      x_v = (opm_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'h0;
      case (opm_r[3:2])
        2'b10:   z_v = p_r;
        2'b11:   z_v = c_r;
        default: z_v = 48'h0;
      endcase
    end

    always @(posedge clk) begin
      if (dsp_ce[g]) begin
        a_r   <= dsp_a[g];
        b_r   <= dsp_b[g];
        m_r   <= a_r * b_r;
        opm_r <= dsp_opmode[g];
        c_r   <= dsp_c[g];
        p_r   <= x_v + z_v;
      end
    end

    dsp48a1_mac_seq #(
      .LEN     ((g == 0) ? 4 : 1),
      .DSP_LAT (DSP_LAT),
      .OPM_DLY (1)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_a       (in_a[g]),
      .in_b       (in_b[g]),
      .res_valid  (res_valid[g]),
      .res_ready  (res_ready[g]),
      .res_p      (res_p[g]),
      .dsp_a      (dsp_a[g]),
      .dsp_b      (dsp_b[g]),
      .dsp_d      (dsp_d[g]),
      .dsp_c      (dsp_c[g]),
      .dsp_opmode (dsp_opmode[g]),
      .dsp_ce     (dsp_ce[g]),
      .dsp_p      (p_r)
`ifdef DSP48A1_MAC_BIAS_EN
      ,
      .bias       (bias[g])
`endif
    );
  end

  task automatic mon_check(input int l, input logic [47:0] got);
    logic [47:0] e;
    checks = checks + 1;
    if ((l == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      errors = errors + 1;
      $display("FAIL res%0d unexpected result got %0h", l, got);
    end else begin
      e = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (got !== e) begin
        errors = errors + 1;
        $display("FAIL res%0d got %0h want %0h", l, got, e);
      end
    end
  endtask

  always @(negedge clk) if (rst_n && res_valid[0] && res_ready[0]) mon_check(0, res_p[0]);
  always @(negedge clk) if (rst_n && res_valid[1] && res_ready[1]) mon_check(1, res_p[1]);
  always @(negedge clk) if (rec) opm_log.push_back(dsp_opmode[0]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_zero(input string name, input int l);
    check({name, "_res"}, {16'h0, res_p[l]}, 64'h0);
    check({name, "_ctl"}, {17'h0, in_ready[l], res_valid[l], dsp_ce[l], dsp_opmode[l], dsp_a[l], dsp_b[l]}, 64'h0);
    check({name, "_cd"}, {dsp_c[l], 16'h0} | {46'h0, dsp_d[l]}, 64'h0);
  endtask

  task automatic send(input int l, input logic [17:0] a, input logic [17:0] b);
    bit done = 1'b0;
    in_valid[l] = 1'b1;
    in_a[l] = a;
    in_b[l] = b;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready[l]) begin
        done = 1'b1;
        hs_cyc = cyc;
      end
      tick();
    end
    if (!done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send%0d handshake timeout", l);
    end
  endtask

  task automatic wait_res(input int l, output int lat);
    bit seen = 1'b0;
    lat = -1;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (res_valid[l]) begin
        seen = 1'b1;
        lat = cyc - hs_cyc;
      end
      tick();
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL wait_res%0d timeout", l);
    end
  endtask

  task automatic run_frame(input int l, input int n, input int gap_at, input int gap_len,
                           input logic [47:0] e, input string name);
    int lat;
    if (l == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    for (int i = 0; i < n; i++) begin
      send(l, va[i], vb[i]);
      if (i == gap_at) begin
        in_valid[l] = 1'b0;
        repeat (gap_len) tick();
      end
    end
    in_valid[l] = 1'b0;
    wait_res(l, lat);
    check({name, "_lat"}, 64'(lat), 64'(DSP_LAT + 2));
  endtask

  task automatic check_opm(input string name, input logic [7:0] e[8], input int n);
    int s = -1;
    int bad = -1;
    checks = checks + 1;
    foreach (opm_log[i]) if (s < 0 && opm_log[i] == e[0]) s = i;
    if (s < 0 || s + n > opm_log.size()) begin
      errors = errors + 1;
      $display("FAIL %s first opmode %0h not seen", name, e[0]);
    end else begin
      for (int i = 0; i < n; i++) if (bad < 0 && opm_log[s+i] !== e[i]) bad = i;
      if (bad >= 0) begin
        errors = errors + 1;
        $display("FAIL %s slot %0d got %0h want %0h", name, bad, opm_log[s+bad], e[bad]);
      end
    end
  endtask

  task automatic set_terms(input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3);
    va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
    va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] eo[8];
    in_valid = '0; in_a = '0; in_b = '0; res_ready = 2'b11; bias = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #6;
    check_zero("rst0", 0);
    check_zero("rst1", 1);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    check("idle_ready", {62'h0, in_ready}, 64'h3);
    check("idle_ce", {62'h0, dsp_ce}, 64'h3);
    check("idle_opm", {56'h0, dsp_opmode[0]}, 64'h08);
    check("idle_c", {16'h0, dsp_c[0]}, 64'h0);

    // 1: back-to-back frame
    set_terms(1, 10, 2, 20, 3, 30, 4, 40);
    opm_log.delete(); rec = 1'b1;
    run_frame(0, 4, -1, 0, 48'd300, "t1");
    repeat (3) tick();
    rec = 1'b0;
    eo = '{EXP_FIRST, 8'h09, 8'h09, 8'h09, 8'h08, 8'h08, 8'h00, 8'h00};
    check_opm("t1_opm", eo, 6);

    // 2: three bubbles between terms 2 and 3
    opm_log.delete(); rec = 1'b1;
    run_frame(0, 4, 1, 3, 48'd300, "t2");
    repeat (3) tick();
    rec = 1'b0;
    eo = '{EXP_FIRST, 8'h09, 8'h08, 8'h08, 8'h08, 8'h09, 8'h09, 8'h08};
    check_opm("t2_opm", eo, 8);

    // 3: signed operands
    va[0] = -18'sd3; vb[0] = 18'sd5;
    run_frame(1, 1, -1, 0, 48'hFFFF_FFFF_FFF1, "t3a");
    va[0] = 18'sd7; vb[0] = 18'sd6;
    run_frame(1, 1, -1, 0, 48'd42, "t3b");
    set_terms(18'h20000, 18'h20000, 18'h20000, 18'h20000,
              18'h20000, 18'h20000, 18'h20000, 18'h20000);
    run_frame(0, 4, -1, 0, 48'd68719476736, "t3c");
    tick();

    // 4: result backpressure, stray in_valid while held
    res_ready[0] = 1'b0;
    set_terms(1, 10, 2, 20, 3, 30, 4, 40);
    run_frame(0, 4, -1, 0, 48'd300, "t4a");
    in_valid[0] = 1'b1; in_a[0] = 18'd9; in_b[0] = 18'd9;
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (!res_valid[0] || res_p[0] !== 48'd300 || in_ready[0]) bad++;
        tick();
      end
      check("t4_hold", 64'(bad), 64'h0);
    end
    in_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    tick(); tick();
    set_terms(5, 5, 5, 5, 5, 5, 5, 5);
    run_frame(0, 4, -1, 0, 48'd100, "t4b");
    tick();

    // 5a: reset mid-frame
    set_terms(1, 1, 1, 1, 1, 1, 1, 1);
    send(0, 18'd1, 18'd1);
    send(0, 18'd1, 18'd1);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst", 0);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    run_frame(0, 4, -1, 0, 48'd4, "t5a");
    tick();

    // 5b: abort mid-frame
    send(0, 18'd1, 18'd1);
    send(0, 18'd1, 18'd1);
    in_valid[0] = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_opm", {56'h0, dsp_opmode[0]}, 64'h00);
    check("t5_abort_flags", {62'h0, res_valid[0], in_ready[0]}, 64'h1);
    tick();
    run_frame(0, 4, -1, 0, 48'd4, "t5b");
    tick();

`ifdef DSP48A1_MAC_BIAS_EN
    // 6: bias cancels the dot product
    bias[0] = 48'hFFFF_FFFF_FED4;
    set_terms(1, 10, 2, 20, 3, 30, 4, 40);
    run_frame(0, 4, -1, 0, 48'd0, "t6");
    check("t6_c", {16'h0, dsp_c[0]}, {16'h0, 48'hFFFF_FFFF_FED4});
    bias[0] = '0;
    tick();
`endif

    repeat (3) tick();
    check("sb_empty", 64'(exp_q0.size() + exp_q1.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
